// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared control-field layout and ALUOp encodings for the CPU datapath
package cpu_pkg;

  localparam int ALUOP_BITS = 2;
  localparam int CTRL_W     = ALUOP_BITS + 6;

  // Bit positions inside {ALUOp, ALUSrc, RegDst, MemRead, MemWrite, MemtoReg, RegWrite}
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_MEMREAD   = 3;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_ALUOP_LSB = 6;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic [ALUOP_BITS-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluOp_e;

  function automatic logic ctrlMemRead(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// rtl/load_use_detector.sv - flags an ID instruction that reads the register a load in EX writes
module load_use_detector #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exValid,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRtAddr,
  input  logic                  idValid,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] idRsAddr,
  input  logic [REG_ADDR_W-1:0] idRtAddr,
  input  logic                  idUsesRt,
  output logic                  stall
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRtAddr == idRsAddr);
  assign rtMatch = idUsesRt && (exRtAddr == idRtAddr);

  // $0 is hardwired, so a load targeting it can never create a dependence
  assign stall = exValid && exMemRead && (exRtAddr != '0) && idValid && !flush &&
                 (rsMatch || rtMatch);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  ID_Valid_i,
  input  logic [REG_ADDR_W-1:0] ID_RsAddr_i,
  input  logic [REG_ADDR_W-1:0] ID_RtAddr_i,
  input  logic [REG_ADDR_W-1:0] ID_RdAddr_i,
  input  logic                  ID_UsesRt_i,
  input  logic [DATA_W-1:0]     ID_RsData_i,
  input  logic [DATA_W-1:0]     ID_RtData_i,
  input  logic [DATA_W-1:0]     ID_Imm_i,
  input  logic [ALUOP_W+5:0]    ID_Ctrl_i,
  output logic                  stall_o,
  output logic                  EX_Valid_o,
  output logic [REG_ADDR_W-1:0] EX_RsAddr_o,
  output logic [REG_ADDR_W-1:0] EX_RtAddr_o,
  output logic [REG_ADDR_W-1:0] EX_RdAddr_o,
  output logic [DATA_W-1:0]     EX_RsData_o,
  output logic [DATA_W-1:0]     EX_RtData_o,
  output logic [DATA_W-1:0]     EX_Imm_o,
  output logic [ALUOP_W+5:0]    EX_Ctrl_o
);

  logic bubble;

  load_use_detector #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detector (
    .exValid   (EX_Valid_o),
    .exMemRead (EX_Ctrl_o[CTRL_MEMREAD]),
    .exRtAddr  (EX_RtAddr_o),
    .idValid   (ID_Valid_i),
    .flush     (flush_i),
    .idRsAddr  (ID_RsAddr_i),
    .idRtAddr  (ID_RtAddr_i),
    .idUsesRt  (ID_UsesRt_i),
    .stall     (stall_o)
  );

  // Bubbles clear every field so forwarding comparisons downstream can never hit
  assign bubble = flush_i || stall_o || !ID_Valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || (!hold_i && bubble)) begin
      EX_Valid_o  <= 1'b0;
      EX_RsAddr_o <= '0;
      EX_RtAddr_o <= '0;
      EX_RdAddr_o <= '0;
      EX_RsData_o <= '0;
      EX_RtData_o <= '0;
      EX_Imm_o    <= '0;
      EX_Ctrl_o   <= '0;
    end else if (!hold_i) begin
      EX_Valid_o  <= 1'b1;
      EX_RsAddr_o <= ID_RsAddr_i;
      EX_RtAddr_o <= ID_RtAddr_i;
      EX_RdAddr_o <= ID_RdAddr_i;
      EX_RsData_o <= ID_RsData_i;
      EX_RtData_o <= ID_RtData_i;
      EX_Imm_o    <= ID_Imm_i;
      EX_Ctrl_o   <= ID_Ctrl_i;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed and random-stream checks of id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  localparam logic [7:0] C_LW   = 8'h2B;
  localparam logic [7:0] C_ADD  = 8'h91;
  localparam logic [7:0] C_SW   = 8'h24;
  localparam logic [7:0] C_ADDI = 8'h21;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic        idValid, idUsesRt;
  logic [4:0]  idRs, idRt, idRd;
  logic [31:0] idRsData, idRtData, idImm;
  logic [7:0]  idCtrl;
  logic        stall, exValid;
  logic [4:0]  exRs, exRt, exRd;
  logic [31:0] exRsData, exRtData, exImm;
  logic [7:0]  exCtrl;

  int tests = 0;
  int fails = 0;

  logic        mValid;
  logic [4:0]  mRs, mRt, mRd;
  logic [31:0] mRsData, mRtData, mImm;
  logic [7:0]  mCtrl;
  logic        expStall;
  int          stallRun;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .ID_Valid_i(idValid), .ID_RsAddr_i(idRs), .ID_RtAddr_i(idRt), .ID_RdAddr_i(idRd),
    .ID_UsesRt_i(idUsesRt), .ID_RsData_i(idRsData), .ID_RtData_i(idRtData),
    .ID_Imm_i(idImm), .ID_Ctrl_i(idCtrl), .stall_o(stall), .EX_Valid_o(exValid),
    .EX_RsAddr_o(exRs), .EX_RtAddr_o(exRt), .EX_RdAddr_o(exRd),
    .EX_RsData_o(exRsData), .EX_RtData_o(exRtData), .EX_Imm_o(exImm), .EX_Ctrl_o(exCtrl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic usesRt, input logic [7:0] ctrl);
    idValid  = v;
    idRs     = rs;
    idRt     = rt;
    idRd     = rd;
    idUsesRt = usesRt;
    idRsData = $urandom;
    idRtData = $urandom;
    idImm    = $urandom;
    idCtrl   = ctrl;
  endtask

  task automatic checkEx(input string tag, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic [7:0] ctrl);
    chk({tag, ".valid"}, 64'(exValid), 64'(v));
    chk({tag, ".rs"}, 64'(exRs), 64'(rs));
    chk({tag, ".rt"}, 64'(exRt), 64'(rt));
    chk({tag, ".rd"}, 64'(exRd), 64'(rd));
    chk({tag, ".rsData"}, 64'(exRsData), 64'(rsd));
    chk({tag, ".rtData"}, 64'(exRtData), 64'(rtd));
    chk({tag, ".imm"}, 64'(exImm), 64'(imm));
    chk({tag, ".ctrl"}, 64'(exCtrl), 64'(ctrl));
  endtask

  task automatic checkLoaded(input string tag);
    checkEx(tag, 1'b1, idRs, idRt, idRd, idRsData, idRtData, idImm, idCtrl);
  endtask

  task automatic checkBubble(input string tag);
    checkEx(tag, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'd0);
  endtask

  task automatic checkStall(input string tag, input logic exp);
    #1;
    chk(tag, 64'(stall), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    setId(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, C_LW);

    // reset with live ID inputs
    tick(); checkBubble("rst0"); checkStall("rst0.stall", 1'b0);
    setId(1'b1, 5'd9, 5'd2, 5'd4, 1'b0, C_LW);
    tick(); checkBubble("rst1"); checkStall("rst1.stall", 1'b0);
    rst = 1'b0;
    setId(1'b1, 5'd1, 5'd4, 5'd3, 1'b1, C_ADD);
    checkStall("rel.stall", 1'b0);
    tick(); checkLoaded("rel");

    // lw $2,0($1); add $3,$2,$4
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    checkStall("lw1.stall", 1'b0);
    tick(); checkLoaded("lw1");
    setId(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD);
    checkStall("add.stall", 1'b1);
    tick(); checkBubble("add.bub"); checkStall("add.stall2", 1'b0);
    tick(); checkLoaded("add"); chk("add.rs2", 64'(exRs), 64'd2);

    // lw $2; sw $5,0($2) stalls on rs
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick(); checkLoaded("lw2");
    setId(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, C_SW);
    checkStall("sw.stall", 1'b1);
    tick(); checkBubble("sw.bub"); checkStall("sw.stall2", 1'b0);
    tick(); checkLoaded("sw");

    // lw $2; addi with rt=$2 as destination only: no stall
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick();
    setId(1'b1, 5'd7, 5'd2, 5'd0, 1'b0, C_ADDI);
    checkStall("addi.stall", 1'b0);
    tick(); checkLoaded("addi");

    // load to $0 never stalls
    setId(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, C_LW);
    tick(); checkLoaded("lw0");
    setId(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, C_ADD);
    checkStall("use0.stall", 1'b0);
    tick(); checkLoaded("use0");

    // invalid ID with a matching address: no stall, bubble despite non-zero ctrl
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick();
    setId(1'b0, 5'd2, 5'd2, 5'd3, 1'b1, C_ADD);
    checkStall("inv.stall", 1'b0);
    tick(); checkBubble("inv");

    // hazard together with flush: flush wins
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick();
    setId(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD);
    flush = 1'b1;
    checkStall("fl.stall", 1'b0);
    tick(); checkBubble("fl.bub");
    flush = 1'b0;
    setId(1'b1, 5'd2, 5'd4, 5'd6, 1'b1, C_ADD);
    checkStall("fl.next.stall", 1'b0);
    tick(); checkLoaded("fl.next");

    // hold for 3 cycles with a pending load-use
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick();
    setId(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.ctrl", 64'(exCtrl), 64'(C_LW));
      chk("hold.rt", 64'(exRt), 64'd2);
      chk("hold.valid", 64'(exValid), 64'd1);
    end
    hold = 1'b0;
    checkStall("hold.rel.stall", 1'b1);
    tick(); checkBubble("hold.bub"); checkStall("hold.stall2", 1'b0);
    tick(); checkLoaded("hold.add");

    // back-to-back loads each stall
    setId(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, C_LW);
    tick();
    setId(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, C_LW);
    checkStall("b2b.stall1", 1'b1);
    tick(); checkBubble("b2b.bub1");
    tick(); checkLoaded("b2b.lw");
    setId(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, C_ADD);
    checkStall("b2b.stall2", 1'b1);

    // reset while stalling
    rst = 1'b1;
    tick(); checkBubble("rstStall");
    rst = 1'b0;
    checkStall("rstStall.stall", 1'b0);
    tick(); checkLoaded("rstStall.add");

    // random stream against a reference model
    mValid = exValid; mRs = exRs; mRt = exRt; mRd = exRd;
    mRsData = exRsData; mRtData = exRtData; mImm = exImm; mCtrl = exCtrl;
    stallRun = 0;
    for (int n = 0; n < 300; n++) begin
      setId(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom), 1'($urandom), 8'($urandom));
      rst   = ($urandom_range(0, 49) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      expStall = mValid && mCtrl[3] && (mRt != 5'd0) && idValid && !flush &&
                 ((mRt == idRs) || (idUsesRt && (mRt == idRt)));
      checkStall("rnd.stall", expStall);
      if (stall && !hold) stallRun++;
      else stallRun = 0;
      chk("rnd.stallRun", 64'(stallRun <= 1), 64'd1);
      tick();
      if (rst || (!hold && (flush || expStall || !idValid))) begin
        mValid = 1'b0; mRs = '0; mRt = '0; mRd = '0;
        mRsData = '0; mRtData = '0; mImm = '0; mCtrl = '0;
      end else if (!hold) begin
        mValid = 1'b1; mRs = idRs; mRt = idRt; mRd = idRd;
        mRsData = idRsData; mRtData = idRtData; mImm = idImm; mCtrl = idCtrl;
      end
      checkEx("rnd", mValid, mRs, mRt, mRd, mRsData, mRtData, mImm, mCtrl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
